// File: rtl/cw_obi_loader.sv
// cw_obi_loader
// Moves instruction words from a pair of upstream "valid" flag registers into
// X-HEEP memory over an OBI master port. A section base address is loaded
// first, then each instruction word is written to the current address and
// the address advances by pADDR_INCR after every completed write.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for addr_valid (priority) or instr_valid
// ADDR_CLR   | one-cycle low pulse on rst_addr_valid_n
// ADDR_DROP  | waiting for addr_valid to fall before accepting new work
// REQ        | OBI write request held until gnt is sampled
// RESP       | waiting for rvalid; address/count advance on it
// INSTR_CLR  | one-cycle low pulse on rst_instr_valid_n
// INSTR_DROP | waiting for instr_valid to fall before accepting new work
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid, instruction   upstream instruction word and its flag
//   addr_valid, new_section_address  upstream base address and its flag
//   rst_instr_valid_n, rst_addr_valid_n  active-low flag clear pulses
//   req, we, be, addr, wdata   OBI request channel (master)
//   gnt, rvalid, rdata         OBI grant / response (rdata unused)
//   busy                       high whenever the FSM is not in IDLE
//   word_count                 writes completed since the last address load

module cw_obi_loader #(
  parameter int pDATA_WIDTH = 32,
  parameter int pADDR_INCR  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  input  logic                   addr_valid,
  input  logic [pDATA_WIDTH-1:0] instruction,
  input  logic [pDATA_WIDTH-1:0] new_section_address,
  output logic                   rst_instr_valid_n,
  output logic                   rst_addr_valid_n,
  output logic                   req,
  output logic                   we,
  output logic [3:0]             be,
  output logic [pDATA_WIDTH-1:0] addr,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   gnt,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   busy,
  output logic [15:0]            word_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_CLR   = 3'd1,
    ADDR_DROP  = 3'd2,
    REQ        = 3'd3,
    RESP       = 3'd4,
    INSTR_CLR  = 3'd5,
    INSTR_DROP = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [pDATA_WIDTH-1:0] cur_addr;

  // Write responses carry no data; rdata is intentionally left unobserved.
  logic unused_rdata;
  assign unused_rdata = ^rdata;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (addr_valid) begin
          state_d = ADDR_CLR;
        end else if (instr_valid) begin
          state_d = REQ;
        end
      end
      ADDR_CLR:   state_d = ADDR_DROP;
      ADDR_DROP:  if (!addr_valid)  state_d = IDLE;
      REQ:        if (gnt)          state_d = RESP;
      RESP:       if (rvalid)       state_d = INSTR_CLR;
      INSTR_CLR:  state_d = INSTR_DROP;
      INSTR_DROP: if (!instr_valid) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe (req rises on the same edge the FSM enters REQ).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req               <= 1'b0;
      we                <= 1'b0;
      be                <= 4'h0;
      addr              <= '0;
      busy              <= 1'b0;
      rst_instr_valid_n <= 1'b1;
      rst_addr_valid_n  <= 1'b1;
    end else begin
      req               <= (state_d == REQ);
      we                <= (state_d == REQ);
      be                <= (state_d == REQ) ? 4'hF : 4'h0;
      // cur_addr cannot change on an edge that enters or stays in REQ,
      // so the current value is the address of this request.
      addr              <= (state_d == REQ) ? cur_addr : '0;
      busy              <= (state_d != IDLE);
      rst_instr_valid_n <= (state_d != INSTR_CLR);
      rst_addr_valid_n  <= (state_d != ADDR_CLR);
    end
  end

  // datapath: base address, write data and completed-write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      wdata      <= '0;
      word_count <= 16'h0000;
    end else begin
      if (state_q == IDLE) begin
        if (addr_valid) begin
          cur_addr   <= new_section_address;
          word_count <= 16'h0000;
        end else if (instr_valid) begin
          wdata <= instruction;
        end
      end
      if (state_q == RESP && rvalid) begin
        cur_addr <= cur_addr + pDATA_WIDTH'(pADDR_INCR);
        if (word_count != 16'hFFFF) begin
          word_count <= word_count + 16'h0001;
        end
      end
    end
  end

endmodule

// File: tb/tb_cw_obi_loader.sv
module tb_cw_obi_loader;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        addr_valid;
  logic [31:0] instruction;
  logic [31:0] new_section_address;
  logic        rst_instr_valid_n;
  logic        rst_addr_valid_n;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] word_count;

  cw_obi_loader #(.pDATA_WIDTH(32), .pADDR_INCR(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .instr_valid         (instr_valid),
    .addr_valid          (addr_valid),
    .instruction         (instruction),
    .new_section_address (new_section_address),
    .rst_instr_valid_n   (rst_instr_valid_n),
    .rst_addr_valid_n    (rst_addr_valid_n),
    .req                 (req),
    .we                  (we),
    .be                  (be),
    .addr                (addr),
    .wdata               (wdata),
    .gnt                 (gnt),
    .rvalid              (rvalid),
    .rdata               (rdata),
    .busy                (busy),
    .word_count          (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: where the next write must land and how many writes
  // have completed since the last address load
  logic [31:0] m_addr;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 32'h0;
    m_cnt  = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".req"},   {31'h0, req}, 32'h0);
    check({tag, ".we"},    {31'h0, we}, 32'h0);
    check({tag, ".be"},    {28'h0, be}, 32'h0);
    check({tag, ".addr"},  addr, 32'h0);
    check({tag, ".wdata"}, wdata, 32'h0);
    check({tag, ".busy"},  {31'h0, busy}, 32'h0);
    check({tag, ".wc"},    {16'h0, word_count}, 32'h0);
    check({tag, ".rinv"},  {31'h0, rst_instr_valid_n}, 32'h1);
    check({tag, ".rarv"},  {31'h0, rst_addr_valid_n}, 32'h1);
  endtask

  // Called at a negedge with the FSM idle.
  task automatic do_addr(input logic [31:0] a, input int hold);
    addr_valid          = 1'b1;
    new_section_address = a;
    @(negedge clk);
    new_section_address = $urandom;
    check("addr_pulse", {31'h0, rst_addr_valid_n}, 32'h0);
    check("addr_busy", {31'h0, busy}, 32'h1);
    check("addr_noreq", {31'h0, req}, 32'h0);
    check("addr_wc0", {16'h0, word_count}, 32'h0);
    m_addr = a;
    m_cnt  = 0;
    @(negedge clk);
    check("addr_pulse_end", {31'h0, rst_addr_valid_n}, 32'h1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("addr_hold_busy", {31'h0, busy}, 32'h1);
      check("addr_hold_rarv", {31'h0, rst_addr_valid_n}, 32'h1);
    end
    addr_valid = 1'b0;
    @(negedge clk);
    check("addr_idle", {31'h0, busy}, 32'h0);
  endtask

  // Called at a negedge with the FSM idle.
  task automatic do_write(input logic [31:0] data, input int gdly, input int rdly, input int hold);
    int req_cycles;
    logic [31:0] exp_wc;
    instr_valid = 1'b1;
    instruction = data;
    @(negedge clk);
    instruction = $urandom;   // wdata must already be captured
    req_cycles = 0;
    for (int k = 0; k <= gdly; k++) begin
      if (k > 0) @(negedge clk);
      check("w_req", {31'h0, req}, 32'h1);
      check("w_addr", addr, m_addr);
      check("w_wdata", wdata, data);
      check("w_we_be", {27'h0, we, be}, {27'h0, 1'b1, 4'hF});
      if (req) req_cycles++;
      if (k == gdly) gnt = 1'b1;
    end
    @(negedge clk);
    gnt = 1'b0;
    check("w_req_cycles", req_cycles, gdly + 1);
    check("w_req_drop", {31'h0, req}, 32'h0);
    check("w_resp_busy", {31'h0, busy}, 32'h1);
    for (int j = 0; j < rdly; j++) begin
      gnt = 1'($urandom_range(0, 1));   // grants in RESP must be ignored
      @(negedge clk);
      check("w_resp_wait", {30'h0, req, rst_instr_valid_n}, 32'h1);
    end
    gnt    = 1'b0;
    rvalid = 1'b1;
    @(negedge clk);
    rvalid = 1'b0;
    m_addr = m_addr + 32'd4;
    if (m_cnt < 65535) m_cnt++;
    exp_wc = m_cnt;
    check("w_clr_pulse", {31'h0, rst_instr_valid_n}, 32'h0);
    check("w_wc", {16'h0, word_count}, exp_wc);
    @(negedge clk);
    check("w_clr_end", {31'h0, rst_instr_valid_n}, 32'h1);
    check("w_drop_busy", {31'h0, busy}, 32'h1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("w_hold_noreq", {31'h0, req}, 32'h0);
      check("w_hold_busy", {31'h0, busy}, 32'h1);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    check("w_idle", {31'h0, busy}, 32'h0);
  endtask

  // Stray gnt/rvalid while idle must not move anything.
  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      gnt    = 1'($urandom_range(0, 1));
      rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("noise_idle", {30'h0, busy, req}, 32'h0);
      check("noise_wc", {16'h0, word_count}, m_cnt);
    end
    gnt    = 1'b0;
    rvalid = 1'b0;
  endtask

  initial begin
    rst_n               = 1'b0;
    instr_valid         = 1'b0;
    addr_valid          = 1'b0;
    instruction         = 32'h0;
    new_section_address = 32'h0;
    gnt                 = 1'b0;
    rvalid              = 1'b0;
    rdata               = 32'h0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_rst");

    // address load, then a write with a 3-cycle grant delay
    do_addr(32'h0000_1000, 0);
    do_write(32'hDEAD_BEEF, 3, 0, 0);
    do_write(32'h1234_5678, 0, 0, 0);   // lands at 0x1004

    // simultaneous flags: address first, then the write at the new base
    addr_valid          = 1'b1;
    instr_valid         = 1'b1;
    new_section_address = 32'h0000_2000;
    instruction         = 32'hCAFE_0001;
    @(negedge clk);
    check("sim_addr_first", {30'h0, rst_addr_valid_n, req}, 32'h0);
    m_addr = 32'h0000_2000;
    m_cnt  = 0;
    @(negedge clk);
    addr_valid = 1'b0;
    @(negedge clk);
    check("sim_back_idle", {30'h0, busy, req}, 32'h0);
    do_write(32'hCAFE_0001, 1, 1, 0);

    // address wrap
    do_addr(32'hFFFF_FFFC, 2);
    do_write(32'hA5A5_A5A5, 0, 2, 1);
    do_write(32'h5A5A_5A5A, 2, 0, 0);   // must land at 0x0

    // flag held five cycles after the clear pulse
    do_write(32'h0BAD_F00D, 0, 0, 5);
    idle_noise(4);

    // reset mid-request
    instr_valid = 1'b1;
    instruction = 32'h7777_0000;
    @(negedge clk);
    check("mid_req_up", {31'h0, req}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_rst");
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    model_reset();
    @(negedge clk);
    check("after_rst_idle", {31'h0, busy}, 32'h0);
    do_write(32'h7777_0001, 1, 1, 0);   // address 0

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: do_addr($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3));
        1, 2: do_write($urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
        default: idle_noise($urandom_range(1, 3));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
